// File: rtl/dm_pkg.sv
// Shared debug-module types: DTM op encodings, DMI request/response payloads
// and the dtmcs.dmistat status codes.
package dm;

    localparam int unsigned DmiAbits = 7;
    localparam int unsigned DmiDataW = 32;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2
    } dtm_op_e;

    typedef struct packed {
        logic [DmiAbits-1:0] addr;
        dtm_op_e             op;
        logic [DmiDataW-1:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [DmiDataW-1:0] data;
        logic [1:0]          resp;
    } dmi_resp_t;

    localparam logic [1:0] DMI_NO_ERROR  = 2'd0;
    localparam logic [1:0] DMI_OP_FAILED = 2'd2;
    localparam logic [1:0] DMI_BUSY      = 2'd3;

endpackage

// File: rtl/dmi_jtag_ctrl.sv
// DMIACCESS data register and DMI request sequencer, TCK domain.
// Converts TAP UpdateDr into a valid/ready DMI transaction and keeps sticky status.
module dmi_jtag_ctrl
    import dm::*;
#(
    parameter int unsigned AbitsWidth = 7,
    parameter int unsigned DataWidth  = 32
) (
    input  logic                  tck_i,
    input  logic                  trst_ni,
    input  logic                  test_logic_reset_i,
    input  logic                  capture_dr_i,
    input  logic                  shift_dr_i,
    input  logic                  update_dr_i,
    input  logic                  dmi_access_i,
    input  logic                  dmi_reset_i,
    input  logic                  dmi_tdi_i,
    output logic                  dmi_tdo_o,
    output logic [1:0]            error_o,
    output logic                  dmi_req_valid_o,
    input  logic                  dmi_req_ready_i,
    output logic [AbitsWidth-1:0] dmi_req_addr_o,
    output logic [DataWidth-1:0]  dmi_req_data_o,
    output logic [1:0]            dmi_req_op_o,
    input  logic                  dmi_resp_valid_i,
    output logic                  dmi_resp_ready_o,
    input  logic [DataWidth-1:0]  dmi_resp_data_i,
    input  logic [1:0]            dmi_resp_i
);

    localparam int unsigned DrWidth = AbitsWidth + DataWidth + 2;

    typedef enum logic [2:0] {
        Idle,
        Read,
        WaitReadValid,
        Write,
        WaitWriteValid
    } state_e;

    state_e                state_q, state_d;
    logic [DrWidth-1:0]    dr_q, dr_d;
    logic [AbitsWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0]  data_q, data_d;
    logic [1:0]            error_q, error_d;
    logic                  req_valid_q, req_valid_d;
    logic                  resp_ready_q, resp_ready_d;
    logic [1:0]            req_op_q, req_op_d;

    logic capture, shift, update;
    logic set_busy, set_fail;

    assign capture = capture_dr_i & dmi_access_i;
    assign shift   = shift_dr_i & dmi_access_i;
    assign update  = update_dr_i & dmi_access_i;

    always_comb begin
        state_d  = state_q;
        dr_d     = dr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        error_d  = error_q;
        set_busy = 1'b0;
        set_fail = 1'b0;

        // An access overlapping an in-flight transaction reports busy in the op field.
        if (capture) begin
            if (state_q != Idle) begin
                dr_d     = {addr_q, data_q, DMI_BUSY};
                set_busy = 1'b1;
            end else begin
                dr_d = {addr_q, data_q, error_q};
            end
        end else if (shift) begin
            dr_d = {dmi_tdi_i, dr_q[DrWidth-1:1]};
        end else if (update && error_q == DMI_NO_ERROR) begin
            if (state_q != Idle) begin
                set_busy = 1'b1;
            end else begin
                case (dtm_op_e'(dr_q[1:0]))
                    DTM_READ: begin
                        addr_d  = dr_q[DrWidth-1 -: AbitsWidth];
                        data_d  = dr_q[DataWidth+1:2];
                        state_d = Read;
                    end
                    DTM_WRITE: begin
                        addr_d  = dr_q[DrWidth-1 -: AbitsWidth];
                        data_d  = dr_q[DataWidth+1:2];
                        state_d = Write;
                    end
                    default: ;
                endcase
            end
        end

        case (state_q)
            Read:  if (dmi_req_ready_i) state_d = WaitReadValid;
            Write: if (dmi_req_ready_i) state_d = WaitWriteValid;
            WaitReadValid: begin
                if (dmi_resp_valid_i) begin
                    state_d  = Idle;
                    data_d   = dmi_resp_data_i;
                    set_fail = (dmi_resp_i != 2'd0);
                end
            end
            WaitWriteValid: begin
                if (dmi_resp_valid_i) begin
                    state_d  = Idle;
                    set_fail = (dmi_resp_i != 2'd0);
                end
            end
            default: ;
        endcase

        if (dmi_reset_i) error_d = DMI_NO_ERROR;
        if (set_busy)      error_d = DMI_BUSY;
        else if (set_fail) error_d = DMI_OP_FAILED;

        // TAP reset wipes the register file but lets the DM handshake finish.
        if (test_logic_reset_i) begin
            dr_d    = '0;
            addr_d  = '0;
            data_d  = '0;
            error_d = DMI_NO_ERROR;
        end

        req_valid_d  = (state_d == Read) || (state_d == Write);
        resp_ready_d = (state_d == WaitReadValid) || (state_d == WaitWriteValid);
        case (state_d)
            Read:    req_op_d = DTM_READ;
            Write:   req_op_d = DTM_WRITE;
            default: req_op_d = DTM_NOP;
        endcase
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q      <= Idle;
            dr_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            error_q      <= DMI_NO_ERROR;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            req_op_q     <= DTM_NOP;
        end else begin
            state_q      <= state_d;
            dr_q         <= dr_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            error_q      <= error_d;
            req_valid_q  <= req_valid_d;
            resp_ready_q <= resp_ready_d;
            req_op_q     <= req_op_d;
        end
    end

    assign dmi_tdo_o        = dr_q[0];
    assign error_o          = error_q;
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_req_addr_o   = addr_q;
    assign dmi_req_data_o   = data_q;
    assign dmi_req_op_o     = req_op_q;
    assign dmi_resp_ready_o = resp_ready_q;

endmodule

// File: tb/tb_dmi_jtag_ctrl.sv
// Directed bench for dmi_jtag_ctrl: scans DMIACCESS, plays the debug module
// side by hand and compares against hand-computed values.
module tb_dmi_jtag_ctrl;

    logic        tck = 1'b0;
    logic        trst_n = 1'b0;
    logic        tlr = 1'b0;
    logic        capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0;
    logic        dmi_access = 1'b1;
    logic        dmi_reset = 1'b0;
    logic        tdi = 1'b0;
    logic        tdo;
    logic [1:0]  error;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [6:0]  req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_op;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [31:0] resp_data = '0;
    logic [1:0]  resp = '0;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    logic [6:0]  mon_addr;
    logic [31:0] mon_data;
    logic [1:0]  mon_op;
    logic [40:0] dout;
    int          cnt0;

    always #5 tck = ~tck;

    dmi_jtag_ctrl dut (
        .tck_i(tck), .trst_ni(trst_n), .test_logic_reset_i(tlr),
        .capture_dr_i(capture_dr), .shift_dr_i(shift_dr), .update_dr_i(update_dr),
        .dmi_access_i(dmi_access), .dmi_reset_i(dmi_reset), .dmi_tdi_i(tdi),
        .dmi_tdo_o(tdo), .error_o(error),
        .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready),
        .dmi_req_addr_o(req_addr), .dmi_req_data_o(req_data), .dmi_req_op_o(req_op),
        .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(resp_ready),
        .dmi_resp_data_i(resp_data), .dmi_resp_i(resp)
    );

    // Handshake monitor, sampled mid-low-phase when inputs and outputs are settled.
    always begin
        @(negedge tck);
        #2;
        if (req_valid && req_ready) begin
            req_cnt++;
            mon_addr = req_addr;
            mon_data = req_data;
            mon_op   = req_op;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic dr_scan(input logic [40:0] din, output logic [40:0] dq);
        capture_dr = 1'b1;
        @(negedge tck);
        capture_dr = 1'b0;
        shift_dr   = 1'b1;
        for (int i = 0; i < 41; i++) begin
            dq[i] = tdo;
            tdi   = din[i];
            @(negedge tck);
        end
        shift_dr  = 1'b0;
        update_dr = 1'b1;
        @(negedge tck);
        update_dr = 1'b0;
    endtask

    task automatic accept_req(input int delay);
        int n = 0;
        while (!req_valid && n < 20) begin
            @(negedge tck);
            n++;
        end
        chk("req_valid_wait", req_valid, 1'b1);
        repeat (delay) @(negedge tck);
        chk("req_valid_held", req_valid, 1'b1);
        req_ready = 1'b1;
        @(negedge tck);
        req_ready = 1'b0;
        chk("req_valid_drop", req_valid, 1'b0);
    endtask

    task automatic give_resp(input logic [31:0] d, input logic [1:0] r);
        resp_valid = 1'b1;
        resp_data  = d;
        resp       = r;
        chk("resp_ready", resp_ready, 1'b1);
        @(negedge tck);
        resp_valid = 1'b0;
        chk("idle_after_resp", resp_ready, 1'b0);
    endtask

    task automatic pulse_dmi_reset();
        dmi_reset = 1'b1;
        @(negedge tck);
        dmi_reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge tck);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_resp_ready", resp_ready, 1'b0);
        chk("rst_error", error, 2'd0);
        chk("rst_tdo", tdo, 1'b0);
        trst_n = 1'b1;
        @(negedge tck);

        // Write with ready delayed by 3 TCK
        cnt0 = req_cnt;
        dr_scan({7'h10, 32'h0000_0001, 2'd2}, dout);
        chk("wr_valid_one_after_update", req_valid, 1'b1);
        accept_req(3);
        chk("wr_req_cnt", req_cnt - cnt0, 1);
        chk("wr_addr", mon_addr, 7'h10);
        chk("wr_data", mon_data, 32'h1);
        chk("wr_op", mon_op, 2'd2);
        give_resp(32'h0, 2'd0);
        dr_scan({7'h0, 32'h0, 2'd0}, dout);
        chk("wr_capture", dout, {7'h10, 32'h1, 2'd0});

        // Read returning DEADBEEF
        cnt0 = req_cnt;
        dr_scan({7'h11, 32'h0, 2'd1}, dout);
        accept_req(0);
        chk("rd_op", mon_op, 2'd1);
        chk("rd_addr", mon_addr, 7'h11);
        give_resp(32'hDEAD_BEEF, 2'd0);
        dr_scan({7'h0, 32'h0, 2'd0}, dout);
        chk("rd_capture", dout, {7'h11, 32'hDEAD_BEEF, 2'd0});
        chk("rd_req_cnt", req_cnt - cnt0, 1);

        // Nop and reserved ops
        cnt0 = req_cnt;
        dr_scan({7'h12, 32'h5, 2'd0}, dout);
        repeat (3) @(negedge tck);
        chk("nop_valid", req_valid, 1'b0);
        dr_scan({7'h12, 32'h5, 2'd3}, dout);
        repeat (3) @(negedge tck);
        chk("rsv_valid", req_valid, 1'b0);
        chk("nop_req_cnt", req_cnt - cnt0, 0);
        chk("nop_error", error, 2'd0);

        // Busy: overlapping access while the read response is held off
        cnt0 = req_cnt;
        dr_scan({7'h20, 32'h0, 2'd1}, dout);
        accept_req(0);
        repeat (20) @(negedge tck);
        dr_scan({7'h21, 32'h0, 2'd1}, dout);
        chk("busy_capture_op", dout[1:0], 2'd3);
        chk("busy_error", error, 2'd3);
        chk("busy_no_req", req_cnt - cnt0, 1);
        chk("busy_still_waiting", resp_ready, 1'b1);
        give_resp(32'hCAFE_0000, 2'd0);
        dr_scan({7'h22, 32'h0, 2'd1}, dout);
        repeat (3) @(negedge tck);
        chk("busy_sticky_valid", req_valid, 1'b0);
        chk("busy_sticky_error", error, 2'd3);
        pulse_dmi_reset();
        chk("busy_cleared", error, 2'd0);
        dr_scan({7'h23, 32'h0, 2'd1}, dout);
        accept_req(0);
        chk("busy_after_reset_addr", mon_addr, 7'h23);
        give_resp(32'h0, 2'd0);
        chk("busy_total_req", req_cnt - cnt0, 2);

        // Failed write response sticks until dmireset
        dr_scan({7'h03, 32'h7, 2'd2}, dout);
        accept_req(0);
        give_resp(32'h0, 2'd2);
        chk("fail_error", error, 2'd2);
        cnt0 = req_cnt;
        dr_scan({7'h04, 32'h8, 2'd2}, dout);
        repeat (3) @(negedge tck);
        chk("fail_capture_op", dout[1:0], 2'd2);
        chk("fail_no_req", req_cnt - cnt0, 0);
        chk("fail_sticky", error, 2'd2);
        pulse_dmi_reset();
        chk("fail_cleared", error, 2'd0);

        // Test-Logic-Reset during WaitReadValid
        dr_scan({7'h09, 32'h0, 2'd1}, dout);
        accept_req(0);
        tlr = 1'b1;
        @(negedge tck);
        tlr = 1'b0;
        chk("tlr_error", error, 2'd0);
        chk("tlr_keeps_wait", resp_ready, 1'b1);
        give_resp(32'h0000_1234, 2'd0);
        dr_scan({7'h0, 32'h0, 2'd0}, dout);
        chk("tlr_capture", dout, {7'h00, 32'h0000_1234, 2'd0});

        // Async trst while a request is pending
        cnt0 = req_cnt;
        dr_scan({7'h15, 32'hFFFF_FFFF, 2'd2}, dout);
        chk("trst_pre_valid", req_valid, 1'b1);
        #1 trst_n = 1'b0;
        #1;
        chk("trst_req_valid", req_valid, 1'b0);
        chk("trst_resp_ready", resp_ready, 1'b0);
        chk("trst_error", error, 2'd0);
        chk("trst_tdo", tdo, 1'b0);
        @(negedge tck);
        trst_n = 1'b1;
        repeat (2) @(negedge tck);
        chk("trst_no_req", req_cnt - cnt0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmi_jtag_ctrl.md
# dmi_jtag_ctrl

- Sequences Debug Module Interface (DMI) accesses on behalf of the JTAG TAP.
- Owns the 41-bit DMIACCESS data register (address, data, op).
- When the TAP issues UpdateDr with DMIACCESS selected, it converts the register contents into a valid/ready request to the debug module and collects the response.
- Tracks the sticky DMI error status that the TAP reports in `dtmcs.dmistat`.
- Sits between the TAP (sibling instance) and the debug module, entirely in the TCK domain.

## Interface
Parameters:
- `AbitsWidth`, default 7: DMI address width. Must equal the `abits` value reported in dtmcs.
- `DataWidth`, default 32: DMI data width.

Ports:
- `tck_i` in 1: JTAG test clock; all state on rising edge.
- `trst_ni` in 1: asynchronous, active-low reset.
- `test_logic_reset_i` in 1: TAP is in Test-Logic-Reset.
- `capture_dr_i`, `shift_dr_i`, `update_dr_i` in 1 each: TAP DR state strobes.
- `dmi_access_i` in 1: IR selects DMIACCESS.
- `dmi_reset_i` in 1: dtmcs.dmireset; clears the sticky error.
- `dmi_tdi_i` in 1: serial data from TDI.
- `dmi_tdo_o` out 1: serial data to the TAP TDO mux, equal to `dr_q[0]`.
- `error_o` out 2: sticky DMI status. 0 = ok, 2 = op failed, 3 = busy.
- `dmi_req_valid_o` out 1, `dmi_req_ready_i` in 1: request handshake.
- `dmi_req_addr_o` out AbitsWidth, `dmi_req_data_o` out DataWidth, `dmi_req_op_o` out 2 (1 = read, 2 = write): request payload.
- `dmi_resp_valid_i` in 1, `dmi_resp_ready_o` out 1: response handshake.
- `dmi_resp_data_i` in DataWidth, `dmi_resp_i` in 2 (0 = success, nonzero = failed): response payload.

## Operation
- Registers:
  - `dr_q`, AbitsWidth+DataWidth+2 bits, laid out {addr, data, op}.
  - `addr_q` and `data_q`.
  - `error_q`.
  - FSM `state_q`: Idle, Read, WaitReadValid, Write, WaitWriteValid.
- Capture (`capture_dr_i & dmi_access_i`):
  - If state ≠ Idle: `error_q` becomes 3 and `dr_q` loads {addr_q, data_q, 2'd3}.
  - Otherwise `dr_q` loads {addr_q, data_q, error_q}.
- Shift (`shift_dr_i & dmi_access_i`): `dr_q` ← {dmi_tdi_i, dr_q[MSB:1]}, LSB first.
- Update (`update_dr_i & dmi_access_i`), first matching case applies:
  - `error_q` ≠ 0: no request; the sticky error blocks all accesses.
  - state ≠ Idle: `error_q` ← 3, no request.
  - op = 1: latch `addr_q`/`data_q` from `dr_q`, go to Read.
  - op = 2: latch `addr_q`/`data_q` from `dr_q`, go to Write.
  - op = 0 or 3: no action.
- Read/Write states:
  - `dmi_req_valid_o` = 1 with payload from `addr_q`/`data_q` and the matching op.
  - Advance to WaitReadValid / WaitWriteValid on `dmi_req_ready_i`.
  - Payload is stable while valid is high; valid is never withdrawn before ready.
- Wait states:
  - `dmi_resp_ready_o` = 1; on `dmi_resp_valid_i` return to Idle.
  - On a read response, `data_q` ← `dmi_resp_data_i`.
  - If `dmi_resp_i` ≠ 0, `error_q` ← 2.
  - Reads and writes are handled identically apart from the data update.
- `dmi_reset_i` clears `error_q` to 0. If an error-set condition occurs in the same cycle, the set wins.
- `test_logic_reset_i` clears `dr_q`, `addr_q`, `data_q` and `error_q`. It does not abort the FSM: an in-flight handshake completes, so DM protocol integrity is preserved.

## Timing
- Reset values:
  - `state_q` = Idle; `dr_q`, `addr_q`, `data_q`, `error_q` = 0.
  - `dmi_req_valid_o` = 0, `dmi_resp_ready_o` = 0, `error_o` = 0, `dmi_tdo_o` = 0.
- All outputs are decoded from registered state only; there is no combinational path from handshake inputs.
- `dmi_req_valid_o` rises one TCK after the update strobe.
- The request completes in the cycle where valid and ready are both high.
- Response accept:
  - Earliest in the cycle after request acceptance.
  - Idle is reached one TCK after `dmi_resp_valid_i` is seen.
- Read data appears in `dr_q` at the next capture, with no extra latency.
- `error_o` updates one TCK after the causing event.
- A response that arrives while in Read (request not yet accepted) is ignored.

## Structure
- The shared `dm` package holds:
  - `dtm_op_e` (Nop = 0, Read = 1, Write = 2).
  - `dmi_req_t` and `dmi_resp_t` structs.
  - The DMI status constants (0/2/3).
- The FSM state enum stays local.
- Single module with no sub-module. The TAP is instantiated alongside it, one level up.

## Test plan
- Write: shift {addr 7'h10, data 32'h0000_0001, op 2}, then update → exactly one request with addr 7'h10, data 1, op 2. Ready after 3 TCK → response accepted → next capture shows status 0.
- Read: shift op 1, addr 7'h11; DM returns data 32'hDEAD_BEEF with resp 0 → next capture shifts out {7'h11, 32'hDEAD_BEEF, 2'b00}.
- Busy: issue a read with the response held off 20 TCK, then capture/update again → captured op = 3, `error_o` = 3, no second request. A further update is also ignored until `dmi_reset_i` pulses; after the pulse, `error_o` = 0 and the next access is issued.
- Failure: DM returns resp 2 on a write → `error_o` = 2 and stays 2 across subsequent updates until `dmi_reset_i`.
- Nop/reserved ops: update with op 0 and with op 3 → no request, `error_o` stays 0.
- Reset: assert `trst_ni` with `dmi_req_valid_o` high → all outputs read 0 immediately. Separately, `test_logic_reset_i` during WaitReadValid → the response is still accepted and the FSM reaches Idle.
